ws2812b_frame_ctrl: RTL

//  Bus-mapped frame scheduler for a WS2812B strip. Holds a shadow pixel buffer written by the CPU and

---
 rtl/ws2812b_frame_ctrl_if.sv | 24 ++
 rtl/ws2812b_frame_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ws2812b_frame_ctrl_if.sv
// Bus and pixel-stream signals of the WS2812B frame controller.
// The slave modport is the controller; the master side is the CPU bus and the encoder.
interface ws2812b_frame_ctrl_if;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        we;
    logic        re;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        enc_idle;

    modport slave (
        input  address, write_data, we, re, pix_ready, enc_idle,
        output read_data, pix_data, pix_valid, pix_last
    );

    modport master (
        output address, write_data, we, re, pix_ready, enc_idle,
        input  read_data, pix_data, pix_valid, pix_last
    );
endinterface

// File: rtl/ws2812b_frame_ctrl.sv
// Frame scheduler for a WS2812B strip: a CPU-written shadow buffer is snapshotted per frame,
// streamed pixel by pixel to the bit encoder, and followed by a timed latch gap.
module ws2812b_frame_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int N_LEDS   = 8,
    parameter int RESET_US = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    ws2812b_frame_ctrl_if.slave  bus
);
    // The product overflows 32 bits at the default clock, so it is evaluated in 64 bits.
    localparam longint T_RST_CALC = (longint'(RESET_US) * longint'(CLK_FREQ) + longint'(999_999))
                                    / longint'(1_000_000);
    localparam int T_RST = (T_RST_CALC < 1) ? 1 : int'(T_RST_CALC);
    localparam int GAP_W = (T_RST > 1) ? $clog2(T_RST) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(T_RST - 1);
    localparam logic [3:0]       LAST_IDX = 4'(N_LEDS - 1);

    localparam logic [7:0] ADDR_CTRL   = 8'h40;
    localparam logic [7:0] ADDR_STATUS = 8'h44;
    localparam logic [7:0] ADDR_PERIOD = 8'h48;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [23:0]      shadow [N_LEDS];
    logic [23:0]      active [N_LEDS];
    logic [1:0]       state;
    logic [3:0]       idx;
    logic [GAP_W-1:0] gap;
    logic [23:0]      period;
    logic [23:0]      refresh_cnt;
    logic             auto_en, done, pend;

    logic shadow_hit, wr_shadow, wr_ctrl, wr_period;
    logic refresh_en, refresh_expire, start_req;
    logic [3:0] addr_idx;

    assign addr_idx   = bus.address[5:2];
    assign shadow_hit = (bus.address[1:0] == 2'b00) && (bus.address < 8'(4 * N_LEDS));
    assign wr_shadow  = bus.we && shadow_hit;
    assign wr_ctrl    = bus.we && (bus.address == ADDR_CTRL);
    assign wr_period  = bus.we && (bus.address == ADDR_PERIOD);

    assign refresh_en     = auto_en && (period != 24'd0);
    assign refresh_expire = refresh_en && (refresh_cnt == 24'd0);
    assign start_req      = (wr_ctrl && bus.write_data[0]) || refresh_expire;

    // Reads have no side effects and the upper write byte has no storage behind it.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.re, bus.write_data[31:24]};

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pixel buffers live in flops and are cleared on reset so a reset strip
            // reads back and displays black; don't retarget them to a RAM macro.
            for (int i = 0; i < N_LEDS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            state   <= S_IDLE;
            idx     <= '0;
            gap     <= '0;
            period  <= '0;
            auto_en <= 1'b0;
            done    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            for (int i = 0; i < N_LEDS; i++)
                if (wr_shadow && addr_idx == 4'(i)) shadow[i] <= bus.write_data[23:0];
            if (wr_ctrl)   auto_en <= bus.write_data[1];
            if (wr_period) period  <= bus.write_data[23:0];

            // A latch-gap completion outranks a same-cycle software clear.
            if (state == S_LATCH && gap == '0) done <= 1'b1;
            else if (wr_ctrl && bus.write_data[2]) done <= 1'b0;

            if (start_req && state != S_IDLE) pend <= 1'b1;

            case (state)
                S_IDLE: if (start_req || pend) begin
                    for (int i = 0; i < N_LEDS; i++) active[i] <= shadow[i];
                    idx   <= '0;
                    pend  <= 1'b0;
                    state <= S_SEND;
                end
                S_SEND: if (bus.pix_ready) begin
                    if (idx == LAST_IDX) state <= S_DRAIN;
                    else                 idx   <= idx + 4'd1;
                end
                S_DRAIN: if (bus.enc_idle) begin
                    gap   <= GAP_LOAD;
                    state <= S_LATCH;
                end
                default: begin
                    if (gap == '0) state <= S_IDLE;
                    else           gap   <= gap - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !refresh_en)  refresh_cnt <= '0;
        else if (wr_period)      refresh_cnt <= (bus.write_data[23:0] == 24'd0) ? 24'd0
                                                : bus.write_data[23:0] - 24'd1;
        else if (refresh_expire) refresh_cnt <= period - 24'd1;
        else                     refresh_cnt <= refresh_cnt - 24'd1;
    end

    always_comb begin
        bus.pix_data = '0;
        for (int i = 0; i < N_LEDS; i++)
            if (idx == 4'(i)) bus.pix_data = active[i];
    end

    assign bus.pix_valid = (state == S_SEND);
    assign bus.pix_last  = (state == S_SEND) && (idx == LAST_IDX);

    always_comb begin
        bus.read_data = '0;
        if (bus.address == ADDR_CTRL)
            bus.read_data = {30'b0, auto_en, 1'b0};
        else if (bus.address == ADDR_STATUS)
            bus.read_data = {24'b0, idx, 1'b0, pend, done, state != S_IDLE};
        else if (bus.address == ADDR_PERIOD)
            bus.read_data = {8'b0, period};
        else
            for (int i = 0; i < N_LEDS; i++)
                if (shadow_hit && addr_idx == 4'(i)) bus.read_data = {8'b0, shadow[i]};
    end
endmodule
